// File: rtl/ex_div.sv
// EX-stage radix-2 restoring divider for DIV/DIVU/REM/REMU and W variants.
// Stalls the pipe while iterating; pulses div_valid_o with the final result.
module ex_div #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            div_en_i,
    input  logic [2:0]      div_sel_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            flush_i,
    output logic            div_stall_o,
    output logic            div_valid_o,
    output logic [XLEN-1:0] div_result_o
);

    localparam int HALF = XLEN / 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  quot;
    logic [XLEN-1:0]  dvsr;
    logic             word;
    logic             rem_op;
    logic             neg_q;
    logic             neg_r;

    function automatic logic [XLEN-1:0] wfix(input logic [XLEN-1:0] v,
                                             input logic w);
        return w ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
    endfunction

    logic            is_uns;
    logic            is_rem;
    logic            is_word;
    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic            div_zero;
    logic            ovf;
    logic [XLEN-1:0] sp_res;

    assign is_uns  = div_sel_i[0];
    assign is_rem  = div_sel_i[1];
    assign is_word = div_sel_i[2];

    always_comb begin
        a_ext = src1_i;
        b_ext = src2_i;
        if (is_word) begin
            a_ext = is_uns ? {{HALF{1'b0}}, src1_i[HALF-1:0]}
                           : {{HALF{src1_i[HALF-1]}}, src1_i[HALF-1:0]};
            b_ext = is_uns ? {{HALF{1'b0}}, src2_i[HALF-1:0]}
                           : {{HALF{src2_i[HALF-1]}}, src2_i[HALF-1:0]};
        end
    end

    assign a_neg    = ~is_uns & a_ext[XLEN-1];
    assign b_neg    = ~is_uns & b_ext[XLEN-1];
    assign a_abs    = a_neg ? -a_ext : a_ext;
    assign b_abs    = b_neg ? -b_ext : b_ext;
    assign div_zero = (b_ext == '0);
    assign ovf      = ~is_uns & (&b_ext)
                    & (a_ext == (is_word ? MIN_W : MIN_D));

    always_comb begin
        sp_res = '0;
        if (div_zero) sp_res = is_rem ? a_ext : '1;
        else          sp_res = is_rem ? '0 : a_ext;
        sp_res = wfix(sp_res, is_word);
    end

    // One restoring step; the extra top bit covers unsigned divisors >= 2^63.
    logic [XLEN:0]   sh;
    logic [XLEN:0]   diff;
    logic            ge;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quot_nx;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] fin;
    logic            last_it;

    assign sh      = {rem, quot[XLEN-1]};
    assign diff    = sh - {1'b0, dvsr};
    assign ge      = ~diff[XLEN];
    assign rem_nx  = ge ? diff[XLEN-1:0] : sh[XLEN-1:0];
    assign quot_nx = {quot[XLEN-2:0], ge};
    assign q_fix   = neg_q ? -quot_nx : quot_nx;
    assign r_fix   = neg_r ? -rem_nx : rem_nx;
    assign fin     = wfix(rem_op ? r_fix : q_fix, word);
    assign last_it = (cnt == (word ? CNT_W'(HALF-1) : CNT_W'(XLEN-1)));

    assign div_stall_o = div_en_i & (state != DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            rem          <= '0;
            quot         <= '0;
            dvsr         <= '0;
            word         <= 1'b0;
            rem_op       <= 1'b0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            div_valid_o  <= 1'b0;
            div_result_o <= '0;
        end else if (flush_i) begin
            state       <= IDLE;
            cnt         <= '0;
            div_valid_o <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    div_valid_o <= 1'b0;
                    if (div_en_i) begin
                        word   <= is_word;
                        rem_op <= is_rem;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        dvsr   <= b_abs;
                        rem    <= '0;
                        // Word dividends sit in the top half so 32 shifts suffice.
                        quot   <= is_word ? (a_abs << HALF) : a_abs;
                        cnt    <= '0;
                        if (div_zero | ovf) begin
                            div_result_o <= sp_res;
                            div_valid_o  <= 1'b1;
                            state        <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem  <= rem_nx;
                    quot <= quot_nx;
                    cnt  <= cnt + CNT_W'(1);
                    if (last_it) begin
                        div_result_o <= fin;
                        div_valid_o  <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    div_valid_o <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    div_valid_o <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// Randomized self-checking bench for ex_div against an arithmetic model.
// Checks result, latency, stall span, valid pulse and result hold.
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        div_en_i;
    logic [2:0]  div_sel_i;
    logic [63:0] src1_i;
    logic [63:0] src2_i;
    logic        flush_i;
    logic        div_stall_o;
    logic        div_valid_o;
    logic [63:0] div_result_o;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_res;

    ex_div dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .div_en_i     (div_en_i),
        .div_sel_i    (div_sel_i),
        .src1_i       (src1_i),
        .src2_i       (src2_i),
        .flush_i      (flush_i),
        .div_stall_o  (div_stall_o),
        .div_valid_o  (div_valid_o),
        .div_result_o (div_result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_res(input logic [2:0] sel,
                                            input logic [63:0] a,
                                            input logic [63:0] b);
        logic        uns;
        logic        rm;
        logic [31:0] r32;
        logic [63:0] r64;
        int          sa32;
        int          sb32;
        longint      sa;
        longint      sb;
        uns  = sel[0];
        rm   = sel[1];
        sa32 = a[31:0];
        sb32 = b[31:0];
        sa   = a;
        sb   = b;
        if (sel[2]) begin
            if (b[31:0] == 0)
                r32 = rm ? a[31:0] : 32'hFFFF_FFFF;
            else if (!uns && a[31:0] == 32'h8000_0000 && sb32 == -1)
                r32 = rm ? 32'd0 : a[31:0];
            else if (uns)
                r32 = rm ? a[31:0] % b[31:0] : a[31:0] / b[31:0];
            else
                r32 = rm ? 32'(sa32 % sb32) : 32'(sa32 / sb32);
            return {{32{r32[31]}}, r32};
        end
        if (b == 0)
            r64 = rm ? a : '1;
        else if (!uns && a == 64'h8000_0000_0000_0000 && sb == -1)
            r64 = rm ? 64'd0 : a;
        else if (uns)
            r64 = rm ? a % b : a / b;
        else
            r64 = rm ? 64'(sa % sb) : 64'(sa / sb);
        return r64;
    endfunction

    function automatic int ref_lat(input logic [2:0] sel,
                                   input logic [63:0] a,
                                   input logic [63:0] b);
        if (sel[2]) begin
            if (b[31:0] == 0) return 1;
            if (!sel[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                return 1;
            return 33;
        end
        if (b == 0) return 1;
        if (!sel[0] && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
        return 65;
    endfunction

    function automatic logic [63:0] rnd();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0, 1: v = {$urandom, $urandom};
            2: v = 64'($urandom_range(0, 300));
            3: v = -64'($urandom_range(1, 300));
            4: v = '0;
            5: v = '1;
            6: v = 64'h8000_0000_0000_0000;
            default: v = {$urandom, 32'h8000_0000};
        endcase
        return v;
    endfunction

    // in_done: caller is in the DONE cycle of the previous op and issues
    // the next one back-to-back; otherwise it is issued at the next negedge.
    task automatic do_op(input logic [2:0] sel, input logic [63:0] a,
                         input logic [63:0] b, input bit in_done);
        logic [63:0] exp;
        int          lat;
        int          n;
        int          sn;
        exp = ref_res(sel, a, b);
        lat = ref_lat(sel, a, b);
        if (!in_done) @(negedge clk);
        div_en_i  = 1'b1;
        flush_i   = 1'b0;
        div_sel_i = sel;
        src1_i    = a;
        src2_i    = b;
        if (in_done) @(negedge clk);
        #1;
        chk("valid_at_accept", 64'(div_valid_o), 64'd0);
        chk("result_hold", div_result_o, last_res);
        n  = 0;
        sn = 0;
        forever begin
            if (div_stall_o) sn++;
            if (n > 0 && div_valid_o) break;
            if (n >= 200) break;
            @(negedge clk);
            #1;
            n++;
        end
        chk("latency", 64'(n), 64'(lat));
        chk("stall_cycles", 64'(sn), 64'(lat));
        chk("result", div_result_o, exp);
        last_res = exp;
    endtask

    initial begin
        bit b2b;
        logic [2:0]  sel;
        logic [63:0] a;
        logic [63:0] b;
        rst_n     = 1'b0;
        div_en_i  = 1'b1;
        div_sel_i = 3'b000;
        src1_i    = '0;
        src2_i    = '0;
        flush_i   = 1'b0;
        last_res  = '0;
        #12;
        chk("reset_valid", 64'(div_valid_o), 64'd0);
        chk("reset_result", div_result_o, 64'd0);
        chk("reset_stall_idle", 64'(div_stall_o), 64'd1);
        div_en_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        do_op(3'b001, 64'd100, 64'd7, 0);
        div_en_i = 1'b0;
        do_op(3'b011, 64'd100, 64'd7, 0);
        div_en_i = 1'b0;
        do_op(3'b010, -64'd7, 64'd2, 0);
        div_en_i = 1'b0;
        do_op(3'b000, -64'd7, 64'd2, 0);
        div_en_i = 1'b0;
        do_op(3'b000, 64'h1234, 64'd0, 0);
        div_en_i = 1'b0;
        do_op(3'b010, 64'h1234, 64'd0, 0);
        div_en_i = 1'b0;
        do_op(3'b000, 64'h8000_0000_0000_0000, '1, 0);
        div_en_i = 1'b0;
        do_op(3'b010, 64'h8000_0000_0000_0000, '1, 0);
        div_en_i = 1'b0;
        do_op(3'b100, 64'h8000_0000, '1, 0);
        div_en_i = 1'b0;
        do_op(3'b101, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 0);
        do_op(3'b110, -64'd9, 64'd4, 1);
        do_op(3'b111, 64'h1234, 64'd0, 1);
        div_en_i = 1'b0;

        // Flush at the 10th CALC cycle, then a fresh divu the next cycle.
        @(negedge clk);
        div_en_i  = 1'b1;
        div_sel_i = 3'b001;
        src1_i    = 64'd100;
        src2_i    = 64'd7;
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        do_op(3'b001, 64'd9, 64'd3, 0);
        div_en_i = 1'b0;

        // Flush wins over acceptance of a special-case op.
        @(negedge clk);
        div_en_i  = 1'b1;
        div_sel_i = 3'b000;
        src1_i    = 64'h1234;
        src2_i    = 64'd0;
        flush_i   = 1'b1;
        do_op(3'b011, 64'd1000, 64'd33, 0);
        div_en_i = 1'b0;

        b2b = 1'b0;
        for (int i = 0; i < 40; i++) begin
            sel = 3'($urandom_range(0, 7));
            a   = rnd();
            b   = rnd();
            do_op(sel, a, b, b2b);
            b2b = 1'($urandom_range(0, 1));
            if (!b2b) div_en_i = 1'b0;
        end
        div_en_i = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Multi-cycle radix-2 restoring integer divider in the EX stage of the pipelined RV64 core.
- Consumes the divide enable, divide select and rs1/rs2 operand values that the ID/EX pipeline register produces.
- Holds the pipeline through a stall request until the result is ready, then presents a 64-bit result to the EX result mux.
- Covers DIV/DIVU/REM/REMU and their W variants.

Parameters:
- XLEN, 64, datapath width.
- CNT_W, 7, iteration counter width (covers 0..64).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- div_en_i  in  1  EX instruction is a divide/remainder op
- div_sel_i  in  3  op select. bit0=unsigned, bit1=remainder, bit2=word. 000 div, 001 divu, 010 rem, 011 remu, 100 divw, 101 divuw, 110 remw, 111 remuw
- src1_i  in  XLEN  dividend (forwarded rs1 value)
- src2_i  in  XLEN  divisor (forwarded rs2 value)
- flush_i  in  1  kill in-flight op (branch/trap redirect)
- div_stall_o  out  1  stall request to hazard unit
- div_valid_o  out  1  result valid, one-cycle pulse
- div_result_o  out  XLEN  quotient or remainder

Behaviour:
- Reset, asynchronous: state=IDLE, counter=0, div_valid_o=0, div_result_o=0, internal remainder/quotient registers=0.
- FSM states: IDLE, CALC, DONE.
- IDLE, div_en_i=1, flush_i=0:
  - Latch operands, op select and sign flags.
  - Load |dividend| and |divisor|, go to CALC.
  - Special cases skip CALC and go directly to DONE with the result preloaded.
- Word ops (bit2=1):
  - Operands are src[31:0], sign-extended when signed, zero-extended when unsigned.
  - The iteration count is 32.
  - The final result is res[31:0] sign-extended to 64 bits, for divuw/remuw too.
- 64-bit ops iterate 64 times.
- CALC, once per cycle:
  - Shift {rem,quot} left by 1.
  - Trial subtract the divisor from the upper half; if non-negative, keep the difference and set quot LSB.
  - Increment counter; after the last iteration go to DONE.
- DONE:
  - Sign fix-up: negate the quotient when signed and operand signs differ; the remainder takes the dividend's sign.
  - Register the result into div_result_o and drive div_valid_o=1 for this cycle only.
  - Go to IDLE next cycle.
- Divide by zero, detected in IDLE: quotient = all ones (−1); remainder = dividend (W: low 32 bits sign-extended).
- Signed overflow (most-negative / −1, 64-bit or 32-bit for W): quotient = dividend; remainder = 0.
- Latency from accept cycle t:
  - 64-bit normal: valid at t+65.
  - Word normal: valid at t+33.
  - Special cases: valid at t+1.
- div_stall_o = div_en_i & (state != DONE), combinational.
  - High in the accept cycle and all CALC cycles; low in the DONE cycle so the instruction advances.
- div_result_o holds its last value outside DONE.
- Back-to-back divides: the next op is accepted from IDLE in the cycle after DONE.
- flush_i=1 in any state:
  - Next state IDLE, counter cleared, div_valid_o=0 next cycle.
  - div_result_o unchanged.
  - Flush has priority over acceptance in the same cycle.
- div_en_i dropping mid-CALC without a flush does not occur; if it does, the op completes and the result is discarded by the consumer.

Test Plan:
- divu: src1=100, src2=7, sel=001 → stall high 65 cycles, valid pulse at t+65, result=14. remu same operands → 2.
- rem: src1=−7, src2=2, sel=010 → result=−1 (0xFFFF_FFFF_FFFF_FFFF). div same operands → −3.
- Divide by zero: src1=0x1234, src2=0, sel=000 → result=all ones at t+1. rem → 0x1234.
- Overflow: src1=0x8000_0000_0000_0000, src2=−1, sel=000 → result=src1 at t+1. rem → 0. divw with src1=0x8000_0000 → 0xFFFF_FFFF_8000_0000.
- divuw: src1=0xFFFF_FFFF_FFFF_FFFE, src2=2 → result=0x0000_0000_7FFF_FFFF? No: zero-extended 32-bit 0xFFFF_FFFE/2=0x7FFF_FFFF, valid at t+33. remw src1=−9, src2=4 → −1.
- Flush at the 10th CALC cycle → IDLE next cycle, no valid pulse. A new divu 9/3 issued the following cycle → result=3 at t+65, and the prior result_o is unchanged until then.
